// File: rtl/hd_pio_link_master.sv
// Half-duplex single-wire link initiator on one tristate PIO pad.
// Sends a request frame, turns the pad around, then receives a response frame.
module hd_pio_link_master #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4,
  parameter int TA_CYCLES  = 2,
  parameter int TIMEOUT    = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              pad_i,
  output logic              pad_o,
  output logic              pad_t
);

  localparam int CMAX = (BIT_CYCLES > TA_CYCLES) ? BIT_CYCLES : TA_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int BW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TW   = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] TA_LAST   = CW'(TA_CYCLES - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_W - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TURN,
    RX_WAIT,
    RX_START,
    RX_DATA,
    RX_STOP,
    RESP
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     cyc;
  logic [BW-1:0]     bitcnt;
  logic [TW-1:0]     tmo;
  logic [1:0]        sync;
  logic              pad_s;

  // pad_i is asynchronous; idle line level is 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], pad_i};
    end
  end

  assign pad_s = sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cyc       <= '0;
      bitcnt    <= '0;
      tmo       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      pad_t     <= 1'b1;
      pad_o     <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            shreg     <= req_data;
            cyc       <= '0;
            req_ready <= 1'b0;
            pad_t     <= 1'b0;
            pad_o     <= 1'b0;
            state     <= TX_START;
          end
        end
        TX_START: begin
          if (cyc == BIT_LAST) begin
            cyc    <= '0;
            bitcnt <= '0;
            pad_o  <= shreg[0];
            shreg  <= shreg >> 1;
            state  <= TX_DATA;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        TX_DATA: begin
          if (cyc == BIT_LAST) begin
            cyc <= '0;
            if (bitcnt == BITS_LAST) begin
              pad_o <= 1'b1;
              state <= TX_STOP;
            end else begin
              bitcnt <= bitcnt + 1'b1;
              pad_o  <= shreg[0];
              shreg  <= shreg >> 1;
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        TX_STOP: begin
          if (cyc == BIT_LAST) begin
            cyc   <= '0;
            pad_t <= 1'b1;
            pad_o <= 1'b1;
            state <= TURN;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        TURN: begin
          if (cyc == TA_LAST) begin
            cyc   <= '0;
            tmo   <= '0;
            state <= RX_WAIT;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        RX_WAIT: begin
          tmo <= tmo + 1'b1;
          // a start edge wins over an expiring timeout
          if (!pad_s) begin
            cyc   <= '0;
            state <= RX_START;
          end else if (tmo == TMO_LAST) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            state     <= RESP;
          end
        end
        RX_START: begin
          if (cyc == HALF_LAST) begin
            cyc <= '0;
            if (pad_s) begin
              state <= RX_WAIT;
            end else begin
              bitcnt <= '0;
              state  <= RX_DATA;
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        RX_DATA: begin
          if (cyc == BIT_LAST) begin
            cyc   <= '0;
            shreg <= {pad_s, shreg[DATA_W-1:1]};
            if (bitcnt == BITS_LAST) begin
              state <= RX_STOP;
            end else begin
              bitcnt <= bitcnt + 1'b1;
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        RX_STOP: begin
          if (cyc == BIT_LAST) begin
            cyc       <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= ~pad_s;
            rsp_data  <= shreg;
            state     <= RESP;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          pad_t     <= 1'b1;
          pad_o     <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hd_pio_link_master.sv
// Scoreboard bench for hd_pio_link_master with a pad/responder model.
// Expected TX frames and responses are queued by stimulus, checked by monitors.
module tb_hd_pio_link_master;

  localparam int DATA_W = 8;
  localparam int BC     = 4;
  localparam int TA     = 2;
  localparam int TMO    = 256;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              pad_i;
  logic              pad_o;
  logic              pad_t;
  logic              resp_line;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         lat_min;
    int         lat_max;
  } rsp_t;

  rsp_t       rsp_q[$];
  logic [7:0] tx_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc_n = 0;
  int         tx_end_cyc = 0;

  hd_pio_link_master #(
    .DATA_W(DATA_W),
    .BIT_CYCLES(BC),
    .TA_CYCLES(TA),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data(req_data),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .pad_i(pad_i),
    .pad_o(pad_o),
    .pad_t(pad_t)
  );

  // pad: master drives when pad_t=0, else the responder (pulled up when idle)
  assign pad_i = pad_t ? resp_line : pad_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act,
                           input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // TX monitor: full frame shape plus the turnaround release
  initial begin
    logic [7:0] w;
    logic [9:0] fr;
    int bad;
    bit ab;
    forever begin
      @(negedge clk);
      if (!rst && pad_t === 1'b0) begin
        check("tx_q_nonempty", 32'(tx_q.size() != 0), 1);
        w = (tx_q.size() != 0) ? tx_q.pop_front() : 8'h00;
        fr = {1'b1, w, 1'b0};
        bad = 0;
        ab = 0;
        for (int i = 0; i < (DATA_W + 2) * BC; i++) begin
          if (i > 0) @(negedge clk);
          if (rst) begin
            ab = 1;
            break;
          end
          if (pad_t !== 1'b0 || pad_o !== fr[i / BC]) bad++;
        end
        if (!ab) begin
          check("tx_frame", bad, 0);
          for (int k = 0; k < TA; k++) begin
            @(negedge clk);
            if (k == 0) tx_end_cyc = cyc_n;
            check("turn_release", {pad_t, pad_o}, 2'b11);
          end
        end
      end
    end
  end

  // response monitor
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid === 1'b1) begin
        check("rsp_q_nonempty", 32'(rsp_q.size() != 0), 1);
        check("ready_in_resp", req_ready, 0);
        if (rsp_q.size() != 0) begin
          e = rsp_q.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_err", rsp_err, e.err);
          if (e.lat_max != 0)
            check_rng("rsp_latency", cyc_n - tx_end_cyc, e.lat_min, e.lat_max);
        end
        @(negedge clk);
        check("rsp_one_pulse", rsp_valid, 0);
        check("ready_after_resp", req_ready, 1);
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stopb);
    logic [9:0] fr;
    fr = {stopb, d, 1'b0};
    for (int i = 0; i < DATA_W + 2; i++) begin
      resp_line = fr[i];
      repeat (BC) @(negedge clk);
    end
    resp_line = 1'b1;
  endtask

  task automatic glitch();
    resp_line = 1'b0;
    @(negedge clk);
    resp_line = 1'b1;
  endtask

  // mode 0 respond, 1 silent, 2 glitch then frame, 3 late glitch then silent
  task automatic run_txn(input logic [7:0] req, input int mode,
                         input logic [7:0] rd, input logic stopb,
                         input bit pulse, input rsp_t e);
    int n;
    int drv;
    @(negedge clk);
    req_data = req;
    req_valid = 1'b1;
    tx_q.push_back(req);
    rsp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    if (pulse) begin
      repeat (6) @(negedge clk);
      req_valid = 1'b1;
      req_data = 8'hFF;
      check("no_accept_tx", req_ready, 0);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (10) @(negedge clk);
      req_valid = 1'b1;
      check("no_accept_tx", req_ready, 0);
      @(negedge clk);
      req_valid = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pad_t !== 1'b1 && n < 100);
    check("tx_end_seen", pad_t, 1);
    case (mode)
      0: begin
        repeat (TA + 5) @(negedge clk);
        send_frame(rd, stopb);
      end
      2: begin
        repeat (TA + 3) @(negedge clk);
        glitch();
        repeat (10) @(negedge clk);
        send_frame(rd, stopb);
      end
      3: begin
        repeat (TA + 100) @(negedge clk);
        glitch();
      end
      default: ;
    endcase
    n = 0;
    drv = 0;
    while (req_ready !== 1'b1 && n < 700) begin
      @(negedge clk);
      n++;
      if (pad_t !== 1'b1) drv++;
    end
    check("rsp_returned", req_ready, 1);
    check("pad_released_rx", drv, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    req_valid = 1'b0;
    req_data = '0;
    resp_line = 1'b1;
    @(negedge clk);
    check("rst_pad_t", pad_t, 1);
    check("rst_pad_o", pad_o, 1);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_data", rsp_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (pad_t !== 1'b1 || pad_o !== 1'b1 ||
          req_ready !== 1'b1 || rsp_valid !== 1'b0) bad++;
    end
    check("idle", bad, 0);

    run_txn(8'hA5, 0, 8'h3C, 1'b1, 1, '{8'h3C, 1'b0, 0, 0});
    run_txn(8'h11, 1, 8'h00, 1'b1, 0, '{8'h00, 1'b1, 258, 258});
    run_txn(8'h22, 0, 8'h3C, 1'b0, 0, '{8'h3C, 1'b1, 0, 0});
    run_txn(8'h33, 2, 8'h81, 1'b1, 0, '{8'h81, 1'b0, 0, 0});
    run_txn(8'h44, 3, 8'h00, 1'b1, 0, '{8'h00, 1'b1, 259, 262});

    // reset in the middle of TX_DATA
    @(negedge clk);
    req_data = 8'h5A;
    req_valid = 1'b1;
    tx_q.push_back(8'h5A);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("mid_tx_driving", pad_t, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_async_pad_t", pad_t, 1);
    check("rst_async_pad_o", pad_o, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", req_ready, 1);
    check("rst_release_pad_t", pad_t, 1);

    repeat (5) @(negedge clk);
    check("sb_empty", rsp_q.size(), 0);
    check("tx_q_empty", tx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hd_pio_link_master.md
Name: hd_pio_link_master

Overview:
- Initiator end of a single-wire, half-duplex serial link carried on one bidirectional PIO pad.
- Accepts a request word and serialises it onto the pad with the output driver enabled.
- Then releases the pad to high-Z, waits for the remote responder's frame, deserialises it and returns the response word or an error.
- Sits between fabric logic and the pad's T/I/O nets; used by the IO timing fuzzer designs to exercise registered tristate turnaround on every IO_TYPE.

Parameters:
- DATA_W, 8: payload bits per frame, each direction.
- BIT_CYCLES, 4: clock cycles per serial bit; legal values are even and >= 4.
- TA_CYCLES, 2: turnaround cycles with the pad released before receive begins; >= 1.
- TIMEOUT, 256: maximum cycles spent in RX_WAIT before error.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  1  request word valid.
- req_ready  output  1  block idle; request accepted when req_valid && req_ready.
- req_data  input  DATA_W  word to transmit.
- rsp_valid  output  1  one-cycle pulse: response available.
- rsp_data  output  DATA_W  received word; valid only with rsp_valid.
- rsp_err  output  1  qualifies rsp_valid: timeout or bad stop bit.
- pad_i  input  1  pad input value, asynchronous to clk.
- pad_o  output  1  pad output value.
- pad_t  output  1  tristate control; 1 = high-Z, 0 = drive pad_o.

Behaviour:
- Decided interface fact: one clock; reset is asynchronous and active-high.
- Reset values (async, immediate):
  - pad_t=1, pad_o=1, req_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0.
  - State forced to IDLE. Reset mid-frame releases the pad on the same edge as rst asserts.
- pad_i passes through a 2-flop synchroniser (pad_s) before any use.
- Frame format, both directions: start bit 0, DATA_W data bits LSB first, stop bit 1. Each bit lasts BIT_CYCLES.
- All outputs are registered. One bit counter, one cycle counter and one timeout counter are shared across states.
- IDLE:
  - req_ready=1, pad_t=1, pad_o=1.
  - On accept, capture req_data into the shift register and go to TX_START.
- TX_START / TX_DATA / TX_STOP:
  - pad_t=0 starting the cycle after accept, for exactly (DATA_W+2)*BIT_CYCLES cycles.
  - pad_o carries the start bit, then the data bits, then the stop bit.
  - req_ready=0 in every non-IDLE state; req_valid is ignored there.
- TURN:
  - pad_t=1, pad_o=1 for TA_CYCLES cycles; pad_s is ignored.
  - Then go to RX_WAIT with the timeout counter cleared.
- RX_WAIT:
  - pad_t=1; the timeout counter increments each cycle.
  - pad_s==0 -> RX_START.
  - Counter reaches TIMEOUT -> RESP with rsp_err=1, rsp_data=0.
- RX_START:
  - Wait BIT_CYCLES/2 cycles, then re-sample pad_s.
  - If 1: false start, return to RX_WAIT. The timeout counter keeps its value and is not restarted.
  - If 0: go to RX_DATA.
- RX_DATA:
  - Sample pad_s every BIT_CYCLES cycles (mid-bit), DATA_W samples, shifting in LSB first.
  - Then RX_STOP.
- RX_STOP:
  - Sample once BIT_CYCLES later.
  - 0 -> rsp_err=1, rsp_data keeps the received word. 1 -> rsp_err=0.
  - Go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; there is no backpressure.
  - Next cycle: IDLE, req_ready=1.
  - rsp_data and rsp_err hold their values until the next RESP.
- Simultaneous events:
  - Timeout expiring on the same cycle pad_s falls: the start is taken; timeout loses.
  - req_valid during RESP is not accepted until IDLE.
- The pad is never driven outside the TX states.

Test Plan:
- Reset, then idle 10 cycles -> pad_t=1, pad_o=1, req_ready=1, rsp_valid=0 throughout. Assert rst mid-TX_DATA -> pad_t=1 immediately, req_ready=1 after release.
- req_data=0xA5, DATA_W=8, BIT_CYCLES=4 -> starting the cycle after accept:
  - pad_t=0 for 40 cycles.
  - pad_o bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - Then pad_t=1 for TA_CYCLES=2.
  - req_valid pulses during TX are not accepted.
- Responder model drives a 0x3C frame 5 cycles after turnaround -> single rsp_valid pulse, rsp_data=0x3C, rsp_err=0, req_ready=1 the following cycle.
- Responder silent -> after 256 cycles in RX_WAIT: rsp_valid=1, rsp_err=1, rsp_data=0; pad_t stays 1 throughout.
- Responder sends 0x3C with stop bit 0 -> rsp_valid=1, rsp_err=1, rsp_data=0x3C.
- Responder drives 1-cycle low glitch, then a valid 0x81 frame 10 cycles later -> glitch rejected in RX_START, rsp_data=0x81, rsp_err=0; timeout counter not restarted by the glitch.
